// File: rtl/apb_cmd_master_pkg.sv
// Shared types for the APB command master: FSM states, alignment mask, response record.
package apb_cmd_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_cmd_state_e;

  localparam logic [1:0] APB_CMD_ALIGN_MASK = 2'b11;

  // APB3 data buses are at most 32 bits wide.
  localparam int unsigned APB_CMD_RDATA_W = 32;

  typedef struct packed {
    logic [APB_CMD_RDATA_W-1:0] rdata;
    logic                       err;
    logic                       timeout;
  } apb_cmd_rsp_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & APB_CMD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/apb_cmd_master_timeout.sv
// Saturating ACCESS wait-state counter for the APB command master (apb_cmd_timeout).
module apb_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic p_clk,
  input  logic prst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge p_clk or posedge prst) begin
    if (prst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // cnt_q counts wait cycles already finished, so the current one is the last allowed.
  assign expired = (cnt_q >= CNT_LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 master driven by a valid/ready command port.
// Define APB_CMD_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              p_clk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] p_addr,
  output logic              p_sel,
  output logic              p_en,
  output logic              p_write,
  output logic [DATA_W-1:0] p_wrdata,
  input  logic              p_ready,
  input  logic [DATA_W-1:0] p_rdata,
  input  logic              p_slverr
);

  apb_cmd_state_e state_q;
  apb_cmd_rsp_t   rsp_q;
  logic           accept_aligned;
  logic           timed_out;

  assign cmd_ready      = (state_q == IDLE);
  assign accept_aligned = cmd_valid && cmd_ready && !is_misaligned(cmd_addr[1:0]);

`ifdef APB_CMD_TIMEOUT_EN
  apb_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .p_clk  (p_clk),
    .prst   (prst),
    .clear  (accept_aligned),
    .enable ((state_q == ACCESS) && !p_ready),
    .expired(timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  // The APB request registers double as the command holding registers.
  always_ff @(posedge p_clk or posedge prst) begin
    if (prst) begin
      state_q   <= IDLE;
      rsp_q     <= '0;
      rsp_valid <= 1'b0;
      p_addr    <= '0;
      p_sel     <= 1'b0;
      p_en      <= 1'b0;
      p_write   <= 1'b0;
      p_wrdata  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (is_misaligned(cmd_addr[1:0])) begin
              state_q       <= RESP;
              rsp_valid     <= 1'b1;
              rsp_q.rdata   <= '0;
              rsp_q.err     <= 1'b1;
              rsp_q.timeout <= 1'b0;
            end else begin
              state_q  <= SETUP;
              p_sel    <= 1'b1;
              p_en     <= 1'b0;
              p_addr   <= cmd_addr;
              p_write  <= cmd_write;
              p_wrdata <= cmd_wdata;
              rsp_q    <= '0;
            end
          end
        end
        SETUP: begin
          state_q <= ACCESS;
          p_en    <= 1'b1;
        end
        ACCESS: begin
          if (p_ready) begin
            state_q     <= RESP;
            p_sel       <= 1'b0;
            p_en        <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_q.err   <= p_slverr;
            rsp_q.rdata <= (!p_write && !p_slverr) ? APB_CMD_RDATA_W'(p_rdata) : '0;
          end else if (timed_out) begin
            state_q       <= RESP;
            p_sel         <= 1'b0;
            p_en          <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_rdata   = DATA_W'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: APB slave model, response monitor, directed and random commands.
`timescale 1ns/1ps
module tb_apb_cmd_master;

  localparam int unsigned TMO = 16;

  logic        p_clk = 1'b0;
  logic        prst  = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr  = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] p_addr;
  logic        p_sel;
  logic        p_en;
  logic        p_write;
  logic [31:0] p_wrdata;
  logic        p_ready  = 1'b0;
  logic [31:0] p_rdata  = '0;
  logic        p_slverr = 1'b0;

  apb_cmd_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .p_clk(p_clk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .p_addr(p_addr), .p_sel(p_sel), .p_en(p_en), .p_write(p_write), .p_wrdata(p_wrdata),
    .p_ready(p_ready), .p_rdata(p_rdata), .p_slverr(p_slverr)
  );

  always #5 p_clk = ~p_clk;

  int unsigned cyc = 0;
  always @(posedge p_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int unsigned waits;
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
  } xfer_t;

  exp_t  sb_q[$];
  xfer_t sl_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference rules: misaligned -> error one cycle after acceptance; otherwise
  // SETUP + (waits+1) ACCESS cycles, read data only on clean reads.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int unsigned waits, input logic [31:0] rdata, input logic err,
                      input bit expect_rsp);
    exp_t        e;
    xfer_t       x;
    int unsigned n;
    @(negedge p_clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge p_clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    if (addr[1:0] != 2'b00) begin
      e.rdata = '0;
      e.err   = 1'b1;
      e.tmo   = 1'b0;
      e.cyc   = cyc + 1;
    end else begin
      x.addr = addr; x.wr = wr; x.wdata = wdata; x.waits = waits;
      x.rdata = rdata; x.err = err; x.acc = cyc;
      sl_q.push_back(x);
      e.rdata = (!wr && !err) ? rdata : 32'h0;
      e.err   = err;
      e.tmo   = 1'b0;
      e.cyc   = cyc + 3 + waits;
`ifdef APB_CMD_TIMEOUT_EN
      if (waits >= TMO) begin
        e.rdata = '0;
        e.err   = 1'b1;
        e.tmo   = 1'b1;
        e.cyc   = cyc + 2 + TMO;
      end
`endif
    end
    if (expect_rsp) sb_q.push_back(e);
    @(posedge p_clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge p_clk);
      n++;
    end
    check("drain_pending", sb_q.size(), 0);
    repeat (2) @(negedge p_clk);
  endtask

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge p_clk);
      if (p_en && !p_sel) check("p_en_without_p_sel", p_en, 0);
      if (rsp_valid) begin
        check("rsp_p_sel_low", p_sel, 0);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", rsp_err, e.err);
          check("rsp_timeout", rsp_timeout, e.tmo);
          check("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // APB slave model
  initial begin
    xfer_t       cur;
    int unsigned wcnt;
    bit          have;
    have = 0;
    wcnt = 0;
    forever begin
      @(negedge p_clk);
      if (p_sel && !p_en) begin
        p_ready = 1'b0;
        wcnt    = 0;
        if (sl_q.size() == 0) begin
          have = 0;
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_setup: got p_sel=1 at 0x%0h expected no transfer", p_addr);
        end else begin
          cur  = sl_q.pop_front();
          have = 1;
          check("setup_cycle", cyc, cur.acc + 1);
          check("setup_addr", p_addr, cur.addr);
          check("setup_write", p_write, cur.wr);
          if (cur.wr) check("setup_wdata", p_wrdata, cur.wdata);
        end
      end else if (p_sel && p_en) begin
        if (have) begin
          if (wcnt == 0) check("access_cycle", cyc, cur.acc + 2);
          check("access_addr", p_addr, cur.addr);
          check("access_write", p_write, cur.wr);
          if (cur.wr) check("access_wdata", p_wrdata, cur.wdata);
        end
        if (have && wcnt == cur.waits) begin
          p_ready  = 1'b1;
          p_rdata  = cur.rdata;
          p_slverr = cur.err;
          have     = 0;
        end else begin
          p_ready  = 1'b0;
          p_rdata  = $urandom;
          p_slverr = 1'($urandom);
          wcnt++;
        end
      end else begin
        have     = 0;
        p_ready  = 1'b0;
        p_rdata  = $urandom;
        p_slverr = 1'($urandom);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    repeat (2) @(negedge p_clk);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_p_sel", p_sel, 0);
    check("reset_p_en", p_en, 0);
    check("reset_p_wrdata", p_wrdata, 0);
    prst = 1'b0;

    send(1'b1, 32'h0, 32'h1, 0, 32'h0, 1'b0, 1'b1);
    drain();
    send(1'b0, 32'h8, 32'h0, 3, 32'h0000_0123, 1'b0, 1'b1);
    drain();
    send(1'b1, 32'h4, 32'h100, 0, 32'h0, 1'b1, 1'b1);
    drain();
    send(1'b1, 32'h6, 32'h55, 0, 32'h0, 1'b0, 1'b1);
    drain();
`ifdef APB_CMD_TIMEOUT_EN
    send(1'b0, 32'hC, 32'h0, 1000, 32'hABC, 1'b0, 1'b1);
`else
    send(1'b0, 32'hC, 32'h0, 110, 32'hABC, 1'b0, 1'b1);
`endif
    drain();

    // Reset in the middle of ACCESS: the transfer is dropped without a response.
    send(1'b1, 32'h40, 32'hDEAD_BEEF, 6, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge p_clk);
    check("pre_reset_p_en", p_en, 1);
    #2;
    prst = 1'b1;
    #1;
    check("async_p_sel", p_sel, 0);
    check("async_p_en", p_en, 0);
    check("async_p_addr", p_addr, 0);
    check("async_p_write", p_write, 0);
    check("async_p_wrdata", p_wrdata, 0);
    check("async_rsp_valid", rsp_valid, 0);
    @(negedge p_clk);
    prst = 1'b0;
    @(negedge p_clk);
    check("post_reset_cmd_ready", cmd_ready, 1);
    check("post_reset_p_sel", p_sel, 0);
    send(1'b0, 32'h44, 32'h0, 1, 32'h5A5A_0001, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 40; i++) begin
      addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      send(1'($urandom), addr, $urandom, $urandom_range(0, 4), $urandom,
           ($urandom_range(0, 4) == 0), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge p_clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Single-outstanding APB3 master that turns a simple valid/ready command interface into correctly phased APB transfers, with SETUP and ACCESS phases, wait states and error reporting. It sits directly upstream of `apb_clk_counter` and other APB slaves on the same bus. It drives their `p_addr`/`p_sel`/`p_en`/`p_write`/`p_wrdata`, samples `p_ready`/`p_rdata`/`p_slverr`, and returns one response pulse per command.

## Interface

Parameters:
- `ADDR_W`, default 32: APB address width.
- `DATA_W`, default 32: APB data width.
- `TIMEOUT_CYCLES`, default 16: maximum number of ACCESS cycles allowed before abort. Used only when the timeout feature is compiled in. Must be ≥1.

Ports (name, direction, width, meaning):
- `p_clk` in 1: clock, rising edge.
- `prst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on the edge where `cmd_valid & cmd_ready` is high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: byte address.
- `cmd_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle response pulse. There is no backpressure on the response.
- `rsp_rdata` out DATA_W: read data. 0 for writes and for errors.
- `rsp_err` out 1: slave error, misalignment or timeout.
- `rsp_timeout` out 1: the transfer was aborted by timeout.
- `p_addr` out ADDR_W, `p_sel` out 1, `p_en` out 1, `p_write` out 1, `p_wrdata` out DATA_W: APB request.
- `p_ready` in 1, `p_rdata` in DATA_W, `p_slverr` in 1: APB completion.

## Operation

- The FSM has four states: IDLE, SETUP, ACCESS, RESP.
- `cmd_ready` = (state == IDLE). The command is captured into holding registers on acceptance.
- IDLE:
  - Accepted command with `cmd_addr[1:0] != 0` goes to RESP with `rsp_err=1`. No APB transfer is issued.
  - Any other accepted command goes to SETUP.
- SETUP: `p_sel=1`, `p_en=0`; address, write flag and data are driven from the holding registers. Always lasts one cycle, then goes to ACCESS.
- ACCESS: `p_sel=1`, `p_en=1`; the APB request outputs are held stable.
  - `p_ready=1` sampled: go to RESP. Capture `p_slverr` into `rsp_err`. On reads only, capture `p_rdata` into `rsp_rdata`.
  - `p_ready=0`: stay in ACCESS and increment the wait counter.
- RESP: `rsp_valid=1` for exactly one cycle, `p_sel=0`, `p_en=0`. Then go to IDLE.
- `p_addr`/`p_write`/`p_wrdata` hold their last values outside a transfer. `p_wrdata` is 0 after reset.
- `rsp_rdata`, `rsp_err` and `rsp_timeout` are valid only while `rsp_valid=1`. They are cleared on entry to SETUP.
- Commands arriving while `cmd_ready=0` are not accepted. The requester must hold them until accepted.
- Wait counter width is `$clog2(TIMEOUT_CYCLES+1)`. It is cleared on entering SETUP and saturates, never wrapping.
- On `prst`, all outputs go to 0 immediately (`cmd_ready` becomes 1 once the state is IDLE) and state = IDLE. A transfer in progress is dropped and no response is produced.

## Timing

- All APB and response outputs are registered. `cmd_ready` is decoded from state.
- Zero-wait transfer, command accepted at the end of cycle N:
  - N+1: SETUP.
  - N+2: ACCESS.
  - N+3: RESP (`rsp_valid`).
  - N+4: IDLE.
- Each slave wait state adds one ACCESS cycle.
- Misaligned command accepted at the end of cycle N: RESP in N+1.
- Minimum spacing is one command per 4 cycles. `p_sel` drops for at least one cycle between transfers.
- `p_slverr` and `p_rdata` are ignored in any cycle where `p_ready=0`.

## Configuration

- `APB_CMD_TIMEOUT_EN` defined:
  - If the transfer has spent `TIMEOUT_CYCLES` ACCESS cycles with `p_ready=0`, the next edge forces RESP with `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`.
  - `p_ready` arriving in that same final cycle takes priority and completes the transfer normally.
- Macro undefined: ACCESS waits indefinitely. `rsp_timeout` is tied to 0 and the wait counter is not instantiated.

## Structure

- `apb_cmd_master_pkg` holds:
  - the state enum `apb_cmd_state_e` (IDLE, SETUP, ACCESS, RESP);
  - the localparam for the alignment mask;
  - the response struct `apb_cmd_rsp_t` (rdata, err, timeout).
- Sub-module `apb_cmd_timeout`: saturating wait counter with clear/enable inputs and an `expired` output. It is instantiated only under `APB_CMD_TIMEOUT_EN`.

## Test plan

- Write addr 0x0 data 0x1, slave with zero wait states:
  - `p_sel` rises in N+1, `p_en` in N+2;
  - `rsp_valid` in N+3 with `rsp_err=0`, `rsp_rdata=0`.
- Read addr 0x8, slave inserts 3 wait states and then returns 0x0000_0123:
  - ACCESS lasts 4 cycles with address and controls held stable;
  - `rsp_rdata=0x123`, `rsp_err=0`.
- Write addr 0x4 data 0x100, slave asserts `p_slverr` with `p_ready` → `rsp_valid` with `rsp_err=1`, `rsp_timeout=0`.
- Command at addr 0x6 → no `p_sel` assertion; `rsp_valid` with `rsp_err=1` one cycle after acceptance.
- With `APB_CMD_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`, `p_ready` held low → exactly 16 ACCESS cycles, then `rsp_err=1`, `rsp_timeout=1`, `p_sel=0`.
  - Without the macro, the same stimulus keeps the master in ACCESS for 100+ cycles and it completes when `p_ready` finally rises.
- `prst` pulsed during ACCESS:
  - APB outputs are 0 asynchronously and no `rsp_valid` follows;
  - `cmd_ready=1` in the first cycle after release, and the next command completes normally.
